spike_train_decoder: RTL and testbench
======================================

// Module: spike_train_decoder
// PURPOSE
//   Receive end of the neuron's membrane-voltage output bus. Takes signed 8-bit membrane samples
//   (2.6 fixed point, LSB = 1/64) from the Izhikevich core and detects spikes with hysteresis.
//   Measures inter-spike intervals (ISI) in samples, buffers them in a FIFO with a valid/ready drain.
//   Reports windowed spike counts for rate decoding and firing-pattern classification.
// PARAMETERS
//   SPIKE_TH   8'sd16   signed sample threshold; spike when samp >= SPIKE_TH (0.25)
//   REARM_TH   -8'sd32  signed re-arm level; detector re-arms when samp < REARM_TH (-0.5)
//   ISI_W      16       ISI counter / record width (saturating)
//   BURST_MAX  8        ISI <= BURST_MAX marks the record as burst
//   FIFO_DEPTH 4        ISI FIFO entries (power of 2)
//   WIN_LEN    256      rate window length in accepted samples
// PORTS
//   clk         in   1        clock
//   rst         in   1        synchronous reset, active high
//   samp_valid  in   1        samp is valid this cycle; nothing advances when low
//   samp        in   8        signed membrane sample (2.6)
//   spike_o     out  1        1-cycle pulse, one cycle after the crossing sample
//   isi_valid   out  1        FIFO head valid
//   isi_ready   in   1        consumer accepts head when isi_valid & isi_ready
//   isi_data    out  ISI_W+1  {burst, isi}; burst = (isi <= BURST_MAX)
//   overflow    out  1        sticky: an ISI was dropped because FIFO was full
//   rate_valid  out  1        1-cycle pulse at end of each window
//   rate_cnt    out  8        spikes in the window just ended (saturates at 255)
// BEHAVIOUR
//   Reset: state=ARMED, have_prev=0, isi_cnt=0, FIFO empty, win_cnt=0, spk_cnt=0;
//     all outputs 0. Reset mid-operation discards in-flight ISI, FIFO contents and window count.
//   FSM (transitions only on samp_valid):
//     ARMED: samp >= SPIKE_TH -> FIRED, register spike (spike_o=1 next cycle).
//     FIRED: samp <  REARM_TH -> ARMED; any other value stays FIRED (no re-trigger).
//   ISI counter: on the spike sample isi_cnt<=0; on every other accepted sample isi_cnt<=isi_cnt+1,
//     holding at 2^ISI_W-1. On a spike sample with have_prev=1, push {burst, isi_cnt+1 (sat)}.
//     have_prev<=1 on the first spike; the first spike after reset pushes nothing.
//   FIFO: push is visible at head (isi_valid=1) the cycle after the spike sample. Pop on
//     isi_valid & isi_ready. Push while full with no pop: drop the record, overflow<=1 (cleared
//     only by rst). Push and pop in the same cycle while full: both happen, no drop.
//     Pop while empty: ignored. Output order is strictly FIFO; isi_data stable while isi_valid & !isi_ready.
//   Rate: every accepted sample increments win_cnt; the spike sample increments spk_cnt (sat 255).
//     On the WIN_LEN-th sample: rate_cnt <= spk_cnt (+1 if this sample spikes), rate_valid=1 next
//     cycle, win_cnt and spk_cnt cleared. rate_cnt holds its value between windows.
//   All comparisons signed; samp_valid low freezes FSM, counters and window.
// TESTING
//   T1 basic: samples -32,-32,-32,20,20,-40,-32,-32,-32,-32,16 -> spike_o after idx3 and idx10;
//      one ISI record {1,7}; isi_valid 1 cycle after idx10.
//   T2 hysteresis: 20,-10,30,-10,20 (never < -32) -> exactly one spike_o, no ISI.
//   T3 overflow: isi_ready=0, 6 spikes at ISI 10 -> FIFO holds 4 records {0,10}, 5th dropped,
//      overflow=1; then isi_ready=1 drains 4 in order, isi_valid falls.
//   T4 saturation (ISI_W=4): two spikes 40 samples apart -> record isi=15, burst=0.
//   T5 rate (WIN_LEN=16): spikes at samples 2, 9, 16 -> rate_valid after sample 16, rate_cnt=3;
//      next window with no spikes -> rate_cnt=0.
//   T6 rst in FIRED with FIFO non-empty -> FIFO empty, overflow=0; next 20 spikes, no ISI pushed.

Source files
------------

// File: rtl/spike_train_decoder_if.sv
// Sample-in / ISI-out bus of the spike train decoder. The slave side is the decoder itself and
// the master side is the sample producer plus the ISI consumer.
interface spike_train_decoder_if #(
  parameter int unsigned ISI_W = 16
);
  logic               samp_valid;
  logic signed [7:0]  samp;
  logic               isi_valid;
  logic               isi_ready;
  logic [ISI_W:0]     isi_data;

  modport master (output samp_valid, samp, isi_ready, input isi_valid, isi_data);
  modport slave  (input samp_valid, samp, isi_ready, output isi_valid, isi_data);
endinterface

// File: rtl/spike_train_decoder.sv
// Hysteresis spike detector on signed 2.6 membrane samples. It measures inter-spike intervals
// into a small FIFO and reports the spike count per window of accepted samples.
module spike_train_decoder #(
  parameter logic signed [7:0] SPIKE_TH   = 8'sd16,
  parameter logic signed [7:0] REARM_TH   = -8'sd32,
  parameter int unsigned       ISI_W      = 16,
  parameter int unsigned       BURST_MAX  = 8,
  parameter int unsigned       FIFO_DEPTH = 4,
  parameter int unsigned       WIN_LEN    = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  spike_train_decoder_if.slave bus,
  output logic                 spike_o,
  output logic                 overflow,
  output logic                 rate_valid,
  output logic [7:0]           rate_cnt
);
  localparam int unsigned      AW      = $clog2(FIFO_DEPTH);
  localparam int unsigned      CW      = AW + 1;
  localparam int unsigned      WW      = $clog2(WIN_LEN) + 1;
  localparam logic [ISI_W-1:0] ISI_MAX = {ISI_W{1'b1}};

  typedef enum logic [0:0] {ARMED = 1'b0, FIRED = 1'b1} state_e;

  state_e            state_q, state_d;
  logic signed [7:0] samp_s;
  logic              spike_det_s;
  logic              have_prev_q, have_prev_d;
  logic [ISI_W-1:0]  isi_cnt_q, isi_cnt_d, isi_inc_s;
  logic [ISI_W:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q;
  logic              push_req_s, push_s, pop_s;
  logic              spike_q, overflow_q, overflow_d, rate_valid_q, rate_valid_d;
  logic [7:0]        rate_cnt_q, rate_cnt_d, spk_cnt_q, spk_cnt_d, spk_inc_s;
  logic [WW-1:0]     win_cnt_q, win_cnt_d;

  assign samp_s = bus.samp;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARMED;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (bus.samp_valid) begin
      case (state_q)
        ARMED:   if (samp_s >= SPIKE_TH) state_d = FIRED; else state_d = ARMED;
        FIRED:   if (samp_s < REARM_TH)  state_d = ARMED; else state_d = FIRED;
        default: state_d = ARMED;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  always_comb begin
    spike_det_s = 1'b0;
    case (state_q)
      ARMED:   spike_det_s = bus.samp_valid && (samp_s >= SPIKE_TH);
      FIRED:   spike_det_s = 1'b0;
      default: spike_det_s = 1'b0;
    endcase
  end

  // ISI and rate counters advance only on accepted samples; a full FIFO drops unless popped now
  always_comb begin
    isi_inc_s    = (isi_cnt_q == ISI_MAX) ? ISI_MAX : isi_cnt_q + ISI_W'(1);
    spk_inc_s    = (spike_det_s && (spk_cnt_q != 8'hFF)) ? spk_cnt_q + 8'd1 : spk_cnt_q;
    have_prev_d  = have_prev_q;
    isi_cnt_d    = isi_cnt_q;
    win_cnt_d    = win_cnt_q;
    spk_cnt_d    = spk_cnt_q;
    rate_cnt_d   = rate_cnt_q;
    rate_valid_d = 1'b0;
    push_req_s   = 1'b0;
    if (bus.samp_valid) begin
      push_req_s = spike_det_s && have_prev_q;
      if (spike_det_s) begin
        have_prev_d = 1'b1;
        isi_cnt_d   = {ISI_W{1'b0}};
      end else begin
        isi_cnt_d   = isi_inc_s;
      end
      if (win_cnt_q == WW'(WIN_LEN - 1)) begin
        rate_cnt_d   = spk_inc_s;
        rate_valid_d = 1'b1;
        win_cnt_d    = {WW{1'b0}};
        spk_cnt_d    = 8'd0;
      end else begin
        win_cnt_d    = win_cnt_q + WW'(1);
        spk_cnt_d    = spk_inc_s;
      end
    end else begin
      push_req_s = 1'b0;
    end
    pop_s      = (count_q != {CW{1'b0}}) && bus.isi_ready;
    push_s     = push_req_s && ((count_q != CW'(FIFO_DEPTH)) || pop_s);
    overflow_d = overflow_q || (push_req_s && !push_s);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      have_prev_q  <= 1'b0;
      isi_cnt_q    <= {ISI_W{1'b0}};
      wr_ptr_q     <= {AW{1'b0}};
      rd_ptr_q     <= {AW{1'b0}};
      count_q      <= {CW{1'b0}};
      spike_q      <= 1'b0;
      overflow_q   <= 1'b0;
      rate_valid_q <= 1'b0;
      rate_cnt_q   <= 8'd0;
      spk_cnt_q    <= 8'd0;
      win_cnt_q    <= {WW{1'b0}};
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= {(ISI_W + 1){1'b0}};
    end else begin
      have_prev_q  <= have_prev_d;
      isi_cnt_q    <= isi_cnt_d;
      spike_q      <= spike_det_s;
      overflow_q   <= overflow_d;
      rate_valid_q <= rate_valid_d;
      rate_cnt_q   <= rate_cnt_d;
      spk_cnt_q    <= spk_cnt_d;
      win_cnt_q    <= win_cnt_d;
      if (push_s) begin
        mem_q[wr_ptr_q] <= {(isi_inc_s <= ISI_W'(BURST_MAX)), isi_inc_s};
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop_s) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(push_s) - CW'(pop_s);
    end
  end

  assign spike_o       = spike_q;
  assign overflow      = overflow_q;
  assign rate_valid    = rate_valid_q;
  assign rate_cnt      = rate_cnt_q;
  assign bus.isi_valid = (count_q != {CW{1'b0}});
  assign bus.isi_data  = mem_q[rd_ptr_q];
endmodule

// File: tb/tb_spike_train_decoder.sv
// Directed bench for spike_train_decoder (ISI_W=4, WIN_LEN=16) with a behavioural model and an
// expected-ISI queue filled as samples are driven and drained as the DUT hands records out.
module tb_spike_train_decoder;
  logic       clk;
  logic       rst;
  logic       spike_o, overflow, rate_valid;
  logic [7:0] rate_cnt;

  spike_train_decoder_if #(.ISI_W(4)) bus ();

  spike_train_decoder #(.ISI_W(4), .WIN_LEN(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .spike_o    (spike_o),
    .overflow   (overflow),
    .rate_valid (rate_valid),
    .rate_cnt   (rate_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  bit         m_armed, m_have_prev, m_spike, m_ovf, m_rv;
  int         m_isi, m_win, m_spk, m_rate;
  logic [4:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] rec(input int isi);
    logic [3:0] v;
    v   = 4'(isi);
    rec = {(isi <= 8), v};
  endfunction

  task automatic check_outputs();
    chk("spike_o", 32'(spike_o), 32'(m_spike));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("rate_valid", 32'(rate_valid), 32'(m_rv));
    chk("rate_cnt", 32'(rate_cnt), 32'(m_rate));
    chk("isi_valid", 32'(bus.isi_valid), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) chk("isi_data", 32'(bus.isi_data), 32'(exp_q[0]));
  endtask

  task automatic model_reset();
    m_armed = 1'b1; m_have_prev = 1'b0; m_spike = 1'b0; m_ovf = 1'b0; m_rv = 1'b0;
    m_isi = 0; m_win = 0; m_spk = 0; m_rate = 0;
    exp_q.delete();
  endtask

  task automatic do_rst();
    @(negedge clk);
    rst = 1'b1; bus.samp_valid = 1'b0; bus.isi_ready = 1'b0;
    model_reset();
    @(negedge clk);
    check_outputs();
    rst = 1'b0;
  endtask

  // one clock: check what the last edge produced, drive the next sample, advance the model
  task automatic cyc(input logic v, input int s, input logic rdy);
    bit pop, spk;
    int occ, inc, spk_n;
    @(negedge clk);
    check_outputs();
    bus.samp_valid = v; bus.samp = 8'(s); bus.isi_ready = rdy;
    occ = exp_q.size();
    pop = rdy && (occ != 0);
    if (pop) void'(exp_q.pop_front());
    m_spike = 1'b0; m_rv = 1'b0;
    if (v) begin
      spk = m_armed && (s >= 16);
      if (m_armed) begin
        if (s >= 16) m_armed = 1'b0;
      end else if (s < -32) m_armed = 1'b1;
      inc = (m_isi == 15) ? 15 : m_isi + 1;
      if (spk) begin
        if (m_have_prev) begin
          if (occ < 4 || pop) exp_q.push_back(rec(inc));
          else m_ovf = 1'b1;
        end
        m_have_prev = 1'b1;
        m_isi = 0;
      end else m_isi = inc;
      m_spike = spk;
      spk_n = spk ? ((m_spk == 255) ? 255 : m_spk + 1) : m_spk;
      if (m_win == 15) begin
        m_rate = spk_n; m_rv = 1'b1; m_win = 0; m_spk = 0;
      end else begin
        m_win++; m_spk = spk_n;
      end
    end
  endtask

  initial begin
    int t1[11] = '{-32, -32, -32, 20, 20, -40, -32, -32, -32, -32, 16};
    int t2[5]  = '{20, -10, 30, -10, 20};
    rst = 1'b1; bus.samp_valid = 1'b0; bus.samp = 8'sd0; bus.isi_ready = 1'b0;
    model_reset();
    do_rst();

    // T1 basic detection and one burst record {1,7}
    foreach (t1[i]) cyc(1'b1, t1[i], 1'b1);
    for (int i = 0; i < 4; i++) cyc(1'b1, -40, 1'b1);

    // T2 hysteresis: never re-armed, single spike
    do_rst();
    foreach (t2[i]) cyc(1'b1, t2[i], 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b1, -40, 1'b1);

    // T3 overflow with stalled consumer, then drain in order
    do_rst();
    for (int k = 0; k < 6; k++) begin
      cyc(1'b1, 20, 1'b0);
      for (int i = 0; i < 9; i++) cyc(1'b1, -40, 1'b0);
    end
    for (int i = 0; i < 3; i++) cyc(1'b0, 20, 1'b0);
    for (int i = 0; i < 6; i++) cyc(1'b0, 0, 1'b1);

    // T4 ISI saturation at 15
    do_rst();
    cyc(1'b1, 20, 1'b1);
    for (int i = 0; i < 39; i++) cyc(1'b1, -40, 1'b1);
    cyc(1'b1, 20, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b1, -40, 1'b1);

    // burst boundary: ISI 8 is burst, ISI 9 is not
    do_rst();
    cyc(1'b1, 20, 1'b1);
    for (int i = 0; i < 7; i++) cyc(1'b1, -40, 1'b1);
    cyc(1'b1, 20, 1'b1);
    for (int i = 0; i < 8; i++) cyc(1'b1, -40, 1'b1);
    cyc(1'b1, 20, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b1, -40, 1'b1);

    // T5 rate window: spikes at samples 2, 9, 16, invalid cycles in between, then an empty window
    do_rst();
    cyc(1'b1, -40, 1'b1);
    cyc(1'b1, 20, 1'b1);
    for (int i = 0; i < 6; i++) cyc(1'b1, -40, 1'b1);
    cyc(1'b0, 20, 1'b1);
    cyc(1'b0, 20, 1'b1);
    cyc(1'b1, 20, 1'b1);
    for (int i = 0; i < 6; i++) cyc(1'b1, -40, 1'b1);
    cyc(1'b1, 20, 1'b1);
    for (int i = 0; i < 18; i++) cyc(1'b1, -40, 1'b1);

    // T6 reset while FIRED with a record pending, then the next spike pushes nothing
    do_rst();
    cyc(1'b1, 20, 1'b0);
    for (int i = 0; i < 9; i++) cyc(1'b1, -40, 1'b0);
    cyc(1'b1, 20, 1'b0);
    cyc(1'b1, 20, 1'b0);
    do_rst();
    cyc(1'b1, 20, 1'b1);
    for (int i = 0; i < 5; i++) cyc(1'b1, -40, 1'b1);
    @(negedge clk);
    check_outputs();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
